a20_counter_cell_ii: RTL and testbench

//  Counter-cell II: latches involuntary-counter increment pulses for octal counters 24-41 and 50-55.

---
 rtl/a20_pkg.sv | 35 +++
 rtl/a20_req_cell.sv | 30 +++
 rtl/a20_counter_cell_ii.sv | 123 ++++++++++++
 tb/tb_a20_counter_cell_ii.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/a20_pkg.sv
// Shared constants for counter cell II: counter index order, octal addresses and the
// arbitration helper. Index order is also the service priority (index 0 wins).
package a20_pkg;

  localparam int unsigned NumCtr = 20;

  // Counter slots in priority order, lowest octal address first.
  typedef enum logic [4:0] {
    Ctr24, Ctr25, Ctr26, Ctr27, Ctr30, Ctr31, Ctr32, Ctr33, Ctr34, Ctr35,
    Ctr36, Ctr37, Ctr40, Ctr41, Ctr50, Ctr51, Ctr52, Ctr53, Ctr54, Ctr55
  } ctr_e;

  // Octal address per slot: [5:3] high digit, [2:0] low digit.
  localparam logic [5:0] CtrAddr [NumCtr] = '{
    6'o24, 6'o25, 6'o26, 6'o27, 6'o30, 6'o31, 6'o32, 6'o33, 6'o34, 6'o35,
    6'o36, 6'o37, 6'o40, 6'o41, 6'o50, 6'o51, 6'o52, 6'o53, 6'o54, 6'o55
  };

  // Slots 32..41 carry a minus request alongside the plus one.
  localparam logic [NumCtr-1:0] HasMinus = 20'h03FC0;

  // Keep only the lowest-index set bit.
  function automatic logic [NumCtr-1:0] lowest_one(input logic [NumCtr-1:0] v);
    logic [NumCtr-1:0] r;
    r = '0;
    for (int i = NumCtr - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/a20_req_cell.sv
// One request flip-flop: rising-edge detect of an increment pulse, held until cleared.
module a20_req_cell (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  input  logic clr,
  output logic pend
);

  logic prev_q;
  logic pend_q;

  // Edge sets the request once per rising edge; a fresh edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= pulse;
      if (pulse && !prev_q) begin
        pend_q <= 1'b1;
      end else if (clr) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/a20_counter_cell_ii.sv
// Counter cell II: latches involuntary-counter requests for 24-41 and 50-55, arbitrates the
// lowest pending address per service slot and drives select/direction/reset strobes.
// Optional build macro A20_SIMUL_CANCEL_EN: simultaneous plus and minus on one counter cancel.
module a20_counter_cell_ii
  import a20_pkg::*;
(
  input  logic CLOCK,
  input  logic rst,
  input  logic T1P, T2P, T3P, T4P, T5P, T6P,
  input  logic CDUXP, CDUXM, CDUYP, CDUYM, CDUZP, CDUZM,
  input  logic TRNP, TRNM, SHAFTP, SHAFTM,
  input  logic PIPXP, PIPXM, PIPYP, PIPYM, PIPZP, PIPZM,
  input  logic CDUXD, CDUYD, CDUZD, TRUND, SHAFTD, THRSTD,
  input  logic BKTF_, CGA20, CG26, RSSB,
  input  logic OCTAD2, OCTAD3, OCTAD4, OCTAD6,
  input  logic XB2, XB3, XB4, XB7,
  input  logic CA5_, CXB0_, CXB1_, CXB5_, CXB6_,
  output logic CA2_, CA3_, CA4_, CA6_,
  output logic CXB2_, CXB3_, CXB4_, CXB7_,
  output logic C24A, C25A, C26A, C27A, C30A, C31A, C32A, C33A, C34A, C35A,
  output logic C36A, C37A, C40A, C41A, C50A, C51A, C52A, C53A, C54A, C55A,
  output logic C24R, C25R, C26R, C27R, C30R, C31R, C32R, C33R, C34R, C35R,
  output logic C36R, C37R, C40R, C41R, C50R, C51R, C52R, C53R, C54R, C55R,
  output logic C32P, C33P, C34P, C35P, C36P, C37P, C40P, C41P,
  output logic C32M, C33M, C34M, C35M, C36M, C37M, C40M, C41M,
  output logic CG11, CG12, CG13, CG14, CG21, CG22, CG23, CG24
);

  logic [NumCtr-1:0] plus_in, plus_pend, minus_pend, pend, elig, clr_plus;
  logic [NumCtr-1:0] dec, r_raw, a_raw;
  logic [7:0]        minus_in, cxb_n;
  logic [5:2]        ca_n;
  logic              grant;

  assign plus_in  = {THRSTD, SHAFTD, TRUND, CDUZD, CDUYD, CDUXD, PIPZP, PIPYP, PIPXP, SHAFTP,
                     TRNP, CDUZP, CDUYP, CDUXP, T6P, T5P, T4P, T3P, T1P, T2P};
  assign minus_in = {PIPZM, PIPYM, PIPXM, SHAFTM, TRNM, CDUZM, CDUYM, CDUXM};

  // Full active-low address decode: own buffered digits plus decodes from neighbouring cells.
  assign ca_n  = {CA5_, ~OCTAD4, ~OCTAD3, ~OCTAD2};
  assign cxb_n = {~XB7, CXB6_, CXB5_, ~XB4, ~XB3, ~XB2, CXB1_, CXB0_};

  for (genvar i = 0; i < NumCtr; i++) begin : g_ctr
    assign dec[i] = ~ca_n[CtrAddr[i][5:3]] & ~cxb_n[CtrAddr[i][2:0]];

    a20_req_cell u_plus (
      .clk   (CLOCK),
      .rst   (rst),
      .pulse (plus_in[i]),
      .clr   (clr_plus[i]),
      .pend  (plus_pend[i])
    );

    if (HasMinus[i]) begin : g_minus
      logic clr_m;
`ifdef A20_SIMUL_CANCEL_EN
      assign clr_m = r_raw[i] | (plus_pend[i] & minus_pend[i]);
`else
      // With both pending, the reset strobe retires only the plus request serviced this slot.
      assign clr_m = r_raw[i] & ~plus_pend[i];
`endif
      a20_req_cell u_minus (
        .clk   (CLOCK),
        .rst   (rst),
        .pulse (minus_in[i-6]),
        .clr   (clr_m),
        .pend  (minus_pend[i])
      );
    end else begin : g_no_minus
      assign minus_pend[i] = 1'b0;
    end
  end

  assign pend  = plus_pend | minus_pend;
  assign r_raw = {NumCtr{RSSB}} & dec;
  assign grant = ~BKTF_ & CGA20 & ~CG26;

`ifdef A20_SIMUL_CANCEL_EN
  // Opposing requests on one counter net to zero: never selected, both dropped next edge.
  assign elig     = pend & ~(plus_pend & minus_pend);
  assign clr_plus = r_raw | (plus_pend & minus_pend);
`else
  assign elig     = pend;
  assign clr_plus = r_raw;
`endif

  // Priority select: lowest eligible address wins the slot when this cell holds the grant.
  always_comb begin
    a_raw = '0;
    if (grant) begin
      a_raw = lowest_one(elig);
    end
  end

  // All outputs forced inactive while reset is held.
  assign {C55A, C54A, C53A, C52A, C51A, C50A, C41A, C40A, C37A, C36A,
          C35A, C34A, C33A, C32A, C31A, C30A, C27A, C26A, C25A, C24A} = a_raw & {NumCtr{rst}};
  assign {C55R, C54R, C53R, C52R, C51R, C50R, C41R, C40R, C37R, C36R,
          C35R, C34R, C33R, C32R, C31R, C30R, C27R, C26R, C25R, C24R} = r_raw & {NumCtr{rst}};
  assign {C41P, C40P, C37P, C36P, C35P, C34P, C33P, C32P} =
         a_raw[13:6] & plus_pend[13:6] & {8{rst}};
  assign {C41M, C40M, C37M, C36M, C35M, C34M, C33M, C32M} =
         a_raw[13:6] & minus_pend[13:6] & ~plus_pend[13:6] & {8{rst}};

  assign CG11 = rst & (|pend[3:0]);
  assign CG12 = rst & (|pend[7:4]);
  assign CG13 = rst & (|pend[11:8]);
  assign CG14 = rst & (|pend[13:12]);
  assign CG21 = rst & (|pend[15:14]);
  assign CG22 = rst & (|pend[17:16]);
  assign CG23 = rst & (|pend[19:18]);
  assign CG24 = rst & (|pend);

  assign CA2_  = ~(OCTAD2 & rst);
  assign CA3_  = ~(OCTAD3 & rst);
  assign CA4_  = ~(OCTAD4 & rst);
  assign CA6_  = ~(OCTAD6 & rst);
  assign CXB2_ = ~(XB2 & rst);
  assign CXB3_ = ~(XB3 & rst);
  assign CXB4_ = ~(XB4 & rst);
  assign CXB7_ = ~(XB7 & rst);

endmodule

// File: tb/tb_a20_counter_cell_ii.sv
// Scoreboard bench for counter cell II: expectations queued with each stimulus step,
// drained and compared once the outputs have settled.
module tb_a20_counter_cell_ii;

  localparam int FldA = 0, FldR = 1, FldP = 2, FldM = 3, FldCg = 4, FldBuf = 5;

  logic CLOCK = 1'b0;
  logic rst;
  logic T1P, T2P, T3P, T4P, T5P, T6P;
  logic CDUXP, CDUXM, CDUYP, CDUYM, CDUZP, CDUZM, TRNP, TRNM, SHAFTP, SHAFTM;
  logic PIPXP, PIPXM, PIPYP, PIPYM, PIPZP, PIPZM;
  logic CDUXD, CDUYD, CDUZD, TRUND, SHAFTD, THRSTD;
  logic BKTF_, CGA20, CG26, RSSB, OCTAD2, OCTAD3, OCTAD4, OCTAD6, XB2, XB3, XB4, XB7;
  logic CA5_, CXB0_, CXB1_, CXB5_, CXB6_;
  logic CA2_, CA3_, CA4_, CA6_, CXB2_, CXB3_, CXB4_, CXB7_;
  logic C24A, C25A, C26A, C27A, C30A, C31A, C32A, C33A, C34A, C35A;
  logic C36A, C37A, C40A, C41A, C50A, C51A, C52A, C53A, C54A, C55A;
  logic C24R, C25R, C26R, C27R, C30R, C31R, C32R, C33R, C34R, C35R;
  logic C36R, C37R, C40R, C41R, C50R, C51R, C52R, C53R, C54R, C55R;
  logic C32P, C33P, C34P, C35P, C36P, C37P, C40P, C41P;
  logic C32M, C33M, C34M, C35M, C36M, C37M, C40M, C41M;
  logic CG11, CG12, CG13, CG14, CG21, CG22, CG23, CG24;

  a20_counter_cell_ii dut (
    .CLOCK(CLOCK), .rst(rst),
    .T1P(T1P), .T2P(T2P), .T3P(T3P), .T4P(T4P), .T5P(T5P), .T6P(T6P),
    .CDUXP(CDUXP), .CDUXM(CDUXM), .CDUYP(CDUYP), .CDUYM(CDUYM), .CDUZP(CDUZP), .CDUZM(CDUZM),
    .TRNP(TRNP), .TRNM(TRNM), .SHAFTP(SHAFTP), .SHAFTM(SHAFTM),
    .PIPXP(PIPXP), .PIPXM(PIPXM), .PIPYP(PIPYP), .PIPYM(PIPYM), .PIPZP(PIPZP), .PIPZM(PIPZM),
    .CDUXD(CDUXD), .CDUYD(CDUYD), .CDUZD(CDUZD), .TRUND(TRUND), .SHAFTD(SHAFTD),
    .THRSTD(THRSTD), .BKTF_(BKTF_), .CGA20(CGA20), .CG26(CG26), .RSSB(RSSB),
    .OCTAD2(OCTAD2), .OCTAD3(OCTAD3), .OCTAD4(OCTAD4), .OCTAD6(OCTAD6),
    .XB2(XB2), .XB3(XB3), .XB4(XB4), .XB7(XB7),
    .CA5_(CA5_), .CXB0_(CXB0_), .CXB1_(CXB1_), .CXB5_(CXB5_), .CXB6_(CXB6_),
    .CA2_(CA2_), .CA3_(CA3_), .CA4_(CA4_), .CA6_(CA6_),
    .CXB2_(CXB2_), .CXB3_(CXB3_), .CXB4_(CXB4_), .CXB7_(CXB7_),
    .C24A(C24A), .C25A(C25A), .C26A(C26A), .C27A(C27A), .C30A(C30A), .C31A(C31A),
    .C32A(C32A), .C33A(C33A), .C34A(C34A), .C35A(C35A), .C36A(C36A), .C37A(C37A),
    .C40A(C40A), .C41A(C41A), .C50A(C50A), .C51A(C51A), .C52A(C52A), .C53A(C53A),
    .C54A(C54A), .C55A(C55A),
    .C24R(C24R), .C25R(C25R), .C26R(C26R), .C27R(C27R), .C30R(C30R), .C31R(C31R),
    .C32R(C32R), .C33R(C33R), .C34R(C34R), .C35R(C35R), .C36R(C36R), .C37R(C37R),
    .C40R(C40R), .C41R(C41R), .C50R(C50R), .C51R(C51R), .C52R(C52R), .C53R(C53R),
    .C54R(C54R), .C55R(C55R),
    .C32P(C32P), .C33P(C33P), .C34P(C34P), .C35P(C35P), .C36P(C36P), .C37P(C37P),
    .C40P(C40P), .C41P(C41P),
    .C32M(C32M), .C33M(C33M), .C34M(C34M), .C35M(C35M), .C36M(C36M), .C37M(C37M),
    .C40M(C40M), .C41M(C41M),
    .CG11(CG11), .CG12(CG12), .CG13(CG13), .CG14(CG14),
    .CG21(CG21), .CG22(CG22), .CG23(CG23), .CG24(CG24)
  );

  always #5 CLOCK = ~CLOCK;

  // Output groups; bit i of the A/R vectors is priority slot i (24,25,..,41,50,..,55).
  logic [19:0] a_v, r_v;
  logic [7:0]  p_v, m_v, cg_v, buf_v;
  assign a_v   = {C55A, C54A, C53A, C52A, C51A, C50A, C41A, C40A, C37A, C36A,
                  C35A, C34A, C33A, C32A, C31A, C30A, C27A, C26A, C25A, C24A};
  assign r_v   = {C55R, C54R, C53R, C52R, C51R, C50R, C41R, C40R, C37R, C36R,
                  C35R, C34R, C33R, C32R, C31R, C30R, C27R, C26R, C25R, C24R};
  assign p_v   = {C41P, C40P, C37P, C36P, C35P, C34P, C33P, C32P};
  assign m_v   = {C41M, C40M, C37M, C36M, C35M, C34M, C33M, C32M};
  assign cg_v  = {CG24, CG23, CG22, CG21, CG14, CG13, CG12, CG11};
  assign buf_v = {CXB7_, CXB4_, CXB3_, CXB2_, CA6_, CA4_, CA3_, CA2_};

  typedef struct {
    string       tag;
    int          fld;
    logic [19:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] oh(input int i);
    logic [19:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [19:0] observe(input int fld);
    case (fld)
      FldA:    return a_v;
      FldR:    return r_v;
      FldP:    return {12'h0, p_v};
      FldM:    return {12'h0, m_v};
      FldCg:   return {12'h0, cg_v};
      default: return {12'h0, buf_v};
    endcase
  endfunction

  task automatic push(input string tag, input int fld, input logic [19:0] val);
    exp_t e;
    e.tag = tag;
    e.fld = fld;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.fld), e.val);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    {T1P, T2P, T3P, T4P, T5P, T6P} = '0;
    {CDUXP, CDUXM, CDUYP, CDUYM, CDUZP, CDUZM, TRNP, TRNM, SHAFTP, SHAFTM} = '0;
    {PIPXP, PIPXM, PIPYP, PIPYM, PIPZP, PIPZM} = '0;
    {CDUXD, CDUYD, CDUZD, TRUND, SHAFTD, THRSTD} = '0;
    {CGA20, CG26, RSSB, OCTAD2, OCTAD3, OCTAD4, OCTAD6, XB2, XB3, XB4, XB7} = '0;
    {BKTF_, CA5_, CXB0_, CXB1_, CXB5_, CXB6_} = '1;

    // Reset held with active-looking inputs: everything must stay inactive.
    rst = 1'b0; OCTAD2 = 1'b1; XB4 = 1'b1; RSSB = 1'b1; BKTF_ = 1'b0; CGA20 = 1'b1; T2P = 1'b1;
    tick(); tick();
    push("rst_a", FldA, '0); push("rst_r", FldR, '0); push("rst_p", FldP, '0);
    push("rst_m", FldM, '0); push("rst_cg", FldCg, '0); push("rst_buf", FldBuf, 20'hFF);
    drain();
    OCTAD2 = 1'b0; XB4 = 1'b0; RSSB = 1'b0; BKTF_ = 1'b1; T2P = 1'b0; rst = 1'b1;
    tick();

    // T2P -> counter 24 pending; select once granted.
    T2P = 1'b1; tick(); T2P = 1'b0;
    push("t1_cg", FldCg, 20'h81); push("t1_a_nogrant", FldA, '0);
    drain();
    BKTF_ = 1'b0; CGA20 = 1'b1;
    push("t1_a24", FldA, oh(0)); push("t1_buf", FldBuf, 20'hFF);
    drain();

    // 24 and 25 together: 24 wins; reset 24 then 25 is selected.
    T1P = 1'b1; T2P = 1'b1; tick(); T1P = 1'b0; T2P = 1'b0;
    push("t2_a24", FldA, oh(0)); push("t2_cg", FldCg, 20'h81);
    drain();
    OCTAD2 = 1'b1; XB4 = 1'b1; RSSB = 1'b1;
    push("t2_r24", FldR, oh(0)); push("t2_buf", FldBuf, 20'hBE);
    drain();
    tick(); OCTAD2 = 1'b0; XB4 = 1'b0; RSSB = 1'b0;
    push("t2_a25", FldA, oh(1));
    drain();
    OCTAD2 = 1'b1; CXB5_ = 1'b0; RSSB = 1'b1;
    push("t2_r25", FldR, oh(1));
    drain();
    tick(); OCTAD2 = 1'b0; CXB5_ = 1'b1; RSSB = 1'b0;
    push("t2_cg_clr", FldCg, '0); push("t2_a_idle", FldA, '0);
    drain();

    // CDUXP held high: one request only, not re-armed by the held level after a reset.
    CDUXP = 1'b1; repeat (5) tick();
    push("t3_a32", FldA, oh(6)); push("t3_p", FldP, 20'h01); push("t3_m", FldM, '0);
    push("t3_cg", FldCg, 20'h82);
    drain();
    OCTAD3 = 1'b1; XB2 = 1'b1; RSSB = 1'b1;
    push("t3_r32", FldR, oh(6));
    drain();
    tick(); OCTAD3 = 1'b0; XB2 = 1'b0; RSSB = 1'b0;
    tick();
    push("t3_held_once", FldCg, '0);
    drain();
    CDUXP = 1'b0;

    // Plus and minus on counter 40 in the same cycle.
    PIPYP = 1'b1; PIPYM = 1'b1; tick(); PIPYP = 1'b0; PIPYM = 1'b0;
`ifdef A20_SIMUL_CANCEL_EN
    push("t4_a_cancel", FldA, '0); push("t4_cg", FldCg, 20'h88);
    drain();
    tick();
    push("t4_cg_cancel", FldCg, '0);
    drain();
`else
    push("t4_a40", FldA, oh(12)); push("t4_p40", FldP, 20'h40); push("t4_m_first", FldM, '0);
    push("t4_cg", FldCg, 20'h88);
    drain();
    OCTAD4 = 1'b1; CXB0_ = 1'b0; RSSB = 1'b1;
    push("t4_r40", FldR, oh(12));
    drain();
    tick(); OCTAD4 = 1'b0; CXB0_ = 1'b1; RSSB = 1'b0;
    push("t4_a40_m", FldA, oh(12)); push("t4_p_second", FldP, '0);
    push("t4_m40", FldM, 20'h40); push("t4_cg_m", FldCg, 20'h88);
    drain();
    OCTAD4 = 1'b1; CXB0_ = 1'b0; RSSB = 1'b1;
    tick(); OCTAD4 = 1'b0; CXB0_ = 1'b1; RSSB = 1'b0;
    push("t4_cg_clr", FldCg, '0);
    drain();
`endif

    // THRSTD pending under priority inhibit from the higher cell.
    THRSTD = 1'b1; tick(); THRSTD = 1'b0; CG26 = 1'b1;
    push("t5_a_inhib", FldA, '0); push("t5_cg", FldCg, 20'hC0);
    drain();
    CG26 = 1'b0;
    push("t5_a55", FldA, oh(19));
    drain();

    // SHAFTD edge coinciding with C54R: the set wins.
    SHAFTD = 1'b1; CA5_ = 1'b0; XB4 = 1'b1; RSSB = 1'b1;
    push("t6_r54", FldR, oh(18));
    drain();
    tick(); SHAFTD = 1'b0; CA5_ = 1'b1; XB4 = 1'b0; RSSB = 1'b0;
    push("t6_cg", FldCg, 20'hC0); push("t6_a54", FldA, oh(18));
    drain();
    CA5_ = 1'b0; XB4 = 1'b1; RSSB = 1'b1; tick();
    XB4 = 1'b0; CXB5_ = 1'b0; tick();
    CA5_ = 1'b1; CXB5_ = 1'b1; RSSB = 1'b0;
    push("t6_cg_clr", FldCg, '0); push("t6_a_idle", FldA, '0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
